// File: rtl/triangle_plane_setup.sv
// rtl/triangle_plane_setup.sv - face normal, 8-bit normal scaling and plane constant for the packed triangle word
module triangle_plane_setup (
   input  logic         clk,
   input  logic         rst,
   input  logic         tri_valid_in,
   output logic         tri_ready_out,
   input  logic [107:0] cam_vertices_in,
   input  logic [95:0]  screen_in,
   input  logic [15:0]  color_in,
   output logic [159:0] triangle_out,
   output logic         triangle_valid_out,
   input  logic         triangle_ready_in,
   output logic         degenerate_out
);

   typedef enum logic [2:0] {IDLE, EDGE, CROSS, NORM, DOT, OUT} state_t;

   state_t              state;
   logic [107:0]        cam_r;
   logic [95:0]         screen_r;
   logic [15:0]         color_r;
   logic signed [12:0]  e1x, e1y, e1z, e2x, e2y, e2z;
   logic signed [26:0]  cx, cy, cz;

   logic signed [11:0]  v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z;
   logic signed [26:0]  cx_n, cy_n, cz_n;
   logic signed [7:0]   nx, ny, nz;
   logic signed [23:0]  p_sum;
   logic                fits;
   logic                zero_normal;

   assign v1x = cam_r[107:96];
   assign v1y = cam_r[95:84];
   assign v1z = cam_r[83:72];
   assign v2x = cam_r[71:60];
   assign v2y = cam_r[59:48];
   assign v2z = cam_r[47:36];
   assign v3x = cam_r[35:24];
   assign v3y = cam_r[23:12];
   assign v3z = cam_r[11:0];

   assign tri_ready_out = (state == IDLE);

   // Cross product of the two edges; operands widened first so the 27-bit result is exact
   assign cx_n = 27'(e1y) * 27'(e2z) - 27'(e1z) * 27'(e2y);
   assign cy_n = 27'(e1z) * 27'(e2x) - 27'(e1x) * 27'(e2z);
   assign cz_n = 27'(e1x) * 27'(e2y) - 27'(e1y) * 27'(e2x);

   // A component fits in signed 8 bits when bits [26:7] are all copies of the sign
   assign fits = ((&cx[26:7]) | ~(|cx[26:7])) &
                 ((&cy[26:7]) | ~(|cy[26:7])) &
                 ((&cz[26:7]) | ~(|cz[26:7]));

   // Floor shifting never turns a non-zero vector into all-zero before it fits,
   // so an all-zero vector at DOT means the unscaled normal was zero
   assign zero_normal = ~(|cx) & ~(|cy) & ~(|cz);

   assign nx = cx[7:0];
   assign ny = cy[7:0];
   assign nz = cz[7:0];

   // Plane constant n.v1; the true sum fits in 22 bits so 24-bit arithmetic is exact
   assign p_sum = 24'(nx) * 24'(v1x) + 24'(ny) * 24'(v1y) + 24'(nz) * 24'(v1z);

   // Setup sequencer: capture, edges, cross, normalise, dot and output hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         cam_r              <= '0;
         screen_r           <= '0;
         color_r            <= '0;
         e1x                <= '0;
         e1y                <= '0;
         e1z                <= '0;
         e2x                <= '0;
         e2y                <= '0;
         e2z                <= '0;
         cx                 <= '0;
         cy                 <= '0;
         cz                 <= '0;
         triangle_out       <= '0;
         triangle_valid_out <= 1'b0;
         degenerate_out     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (tri_valid_in) begin
                  cam_r    <= cam_vertices_in;
                  screen_r <= screen_in;
                  color_r  <= color_in;
                  state    <= EDGE;
               end
            end
            EDGE: begin
               e1x   <= 13'(v2x) - 13'(v1x);
               e1y   <= 13'(v2y) - 13'(v1y);
               e1z   <= 13'(v2z) - 13'(v1z);
               e2x   <= 13'(v3x) - 13'(v1x);
               e2y   <= 13'(v3y) - 13'(v1y);
               e2z   <= 13'(v3z) - 13'(v1z);
               state <= CROSS;
            end
            CROSS: begin
               cx    <= cx_n;
               cy    <= cy_n;
               cz    <= cz_n;
               state <= NORM;
            end
            NORM: begin
               if (fits) begin
                  state <= DOT;
               end else begin
                  cx <= cx >>> 1;
                  cy <= cy >>> 1;
                  cz <= cz >>> 1;
               end
            end
            DOT: begin
               triangle_out       <= {color_r, screen_r, p_sum, nx, ny, nz};
               degenerate_out     <= zero_normal;
               triangle_valid_out <= 1'b1;
               state              <= OUT;
            end
            OUT: begin
               if (triangle_ready_in) begin
                  triangle_valid_out <= 1'b0;
                  state              <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_triangle_plane_setup.sv
// tb/tb_triangle_plane_setup.sv - self-checking bench for triangle_plane_setup
module tb_triangle_plane_setup;

   typedef int vec9_t [9];

   typedef struct {
      logic [159:0] word;
      bit           deg;
      int           s;
      longint       t_acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tri_valid_in = 1'b0;
   logic         tri_ready_out;
   logic [107:0] cam_vertices_in = '0;
   logic [95:0]  screen_in = '0;
   logic [15:0]  color_in = '0;
   logic [159:0] triangle_out;
   logic         triangle_valid_out;
   logic         triangle_ready_in = 1'b1;
   logic         degenerate_out;

   int   checks = 0;
   int   errors = 0;
   exp_t expq[$];
   bit   seen = 1'b0;
   bit   prev_hs = 1'b0;

   triangle_plane_setup dut (
      .clk                (clk),
      .rst                (rst),
      .tri_valid_in       (tri_valid_in),
      .tri_ready_out      (tri_ready_out),
      .cam_vertices_in    (cam_vertices_in),
      .screen_in          (screen_in),
      .color_in           (color_in),
      .triangle_out       (triangle_out),
      .triangle_valid_out (triangle_valid_out),
      .triangle_ready_in  (triangle_ready_in),
      .degenerate_out     (degenerate_out)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input vec9_t v, input logic [95:0] scr, input logic [15:0] col);
      exp_t r;
      int e1 [3];
      int e2 [3];
      int c [3];
      int p;
      for (int i = 0; i < 3; i++) begin
         e1[i] = v[3+i] - v[i];
         e2[i] = v[6+i] - v[i];
      end
      c[0] = e1[1] * e2[2] - e1[2] * e2[1];
      c[1] = e1[2] * e2[0] - e1[0] * e2[2];
      c[2] = e1[0] * e2[1] - e1[1] * e2[0];
      r.deg = (c[0] == 0) && (c[1] == 0) && (c[2] == 0);
      r.s = 0;
      while (c[0] < -128 || c[0] > 127 || c[1] < -128 || c[1] > 127 || c[2] < -128 || c[2] > 127) begin
         for (int i = 0; i < 3; i++) c[i] = c[i] >>> 1;
         r.s++;
      end
      p = c[0] * v[0] + c[1] * v[1] + c[2] * v[2];
      r.word = {col, scr, 24'(p), 8'(c[0]), 8'(c[1]), 8'(c[2])};
      r.t_acc = 0;
      return r;
   endfunction

   function automatic logic [107:0] pack(input vec9_t v);
      logic [107:0] w;
      for (int i = 0; i < 9; i++) w[107 - 12*i -: 12] = 12'(v[i]);
      return w;
   endfunction

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic send(input vec9_t v, input logic [95:0] scr, input logic [15:0] col);
      exp_t e;
      int   n;
      e = model(v, scr, col);
      @(negedge clk);
      tri_valid_in    = 1'b1;
      cam_vertices_in = pack(v);
      screen_in       = scr;
      color_in        = col;
      n = 0;
      while (!tri_ready_out && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check("accept_timeout", 160'(tri_ready_out), 160'(1));
         tri_valid_in = 1'b0;
         return;
      end
      @(posedge clk);
      e.t_acc = $time;
      expq.push_back(e);
      #1;
      tri_valid_in    = 1'b0;
      cam_vertices_in = {108{1'b1}};
      screen_in       = '1;
      color_in        = '1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 160'(expq.size()), 160'(0));
   endtask

   // Output monitor: every cycle with valid high is compared against the model queue
   always @(negedge clk) begin
      if (rst) begin
         prev_hs = 1'b0;
         seen    = 1'b0;
      end else begin
         if (prev_hs) check("ready_after_hs", 160'(tri_ready_out), 160'(1));
         if (triangle_valid_out) begin
            if (expq.size() == 0) begin
               check("spurious_valid", 160'(triangle_valid_out), 160'(0));
            end else begin
               if (!seen) begin
                  seen = 1'b1;
                  check("latency", 160'($time - expq[0].t_acc),
                        160'((4 + expq[0].s) * 10 + 5));
               end
               check("triangle_out", triangle_out, expq[0].word);
               check("degenerate_out", 160'(degenerate_out), 160'(expq[0].deg));
               check("ready_in_out", 160'(tri_ready_out), 160'(0));
               if (triangle_ready_in) begin
                  void'(expq.pop_front());
                  seen = 1'b0;
               end
            end
         end
         prev_hs = triangle_valid_out && triangle_ready_in;
      end
   end

   initial begin
      vec9_t v_simple, v_norm, v_neg, v_degen, v_mixed;
      logic [95:0] scr;
      exp_t m;
      int n;

      v_simple = '{0, 0, 256, 10, 0, 256, 0, 10, 256};
      v_norm   = '{0, 0, 256, 1000, 0, 256, 0, 1000, 256};
      v_neg    = '{0, 0, 256, 10, 0, 256, 0, -10, 256};
      v_degen  = '{0, 0, 256, 10, 0, 256, 20, 0, 256};
      v_mixed  = '{-100, 50, 300, 200, -300, 400, -500, 600, -700};
      scr      = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};

      m = model(v_simple, scr, 16'hBEEF);
      check("model_simple_low", 160'(m.word[47:0]), 160'(48'h006400_00_00_64));
      check("model_simple_high", 160'(m.word[159:48]),
            160'({16'hBEEF, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6}));
      check("model_simple_s", 160'(m.s), 160'(0));
      m = model(v_norm, scr, 16'h0);
      check("model_norm_s", 160'(m.s), 160'(13));
      check("model_norm_low", 160'(m.word[47:0]), 160'(48'h007A00_00_00_7A));
      m = model(v_neg, scr, 16'h0);
      check("model_neg_low", 160'(m.word[47:0]), 160'(48'hFF9C00_00_00_9C));
      m = model(v_degen, scr, 16'h0);
      check("model_degen", 160'({m.deg, m.word[47:0]}), 160'({1'b1, 48'h0}));

      #12;
      check("reset_valid", 160'(triangle_valid_out), 160'(0));
      check("reset_ready", 160'(tri_ready_out), 160'(1));
      check("reset_out", triangle_out, 160'(0));
      check("reset_degen", 160'(degenerate_out), 160'(0));
      @(negedge clk);
      rst = 1'b0;

      send(v_simple, scr, 16'hBEEF);
      send(v_norm, scr, 16'h1234);
      send(v_neg, {16'hFFFF, 16'h0, 16'h8000, 16'h7FFF, 16'hA5A5, 16'h5A5A}, 16'h0F0F);
      send(v_degen, scr, 16'hCAFE);
      send(v_mixed, scr, 16'h7777);
      drain();

      triangle_ready_in = 1'b0;
      send(v_simple, scr, 16'hBEEF);
      n = 0;
      while (!triangle_valid_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_timeout", 160'(triangle_valid_out), 160'(1));
      repeat (5) @(negedge clk);
      triangle_ready_in = 1'b1;
      send(v_neg, scr, 16'h4321);
      drain();

      send(v_norm, scr, 16'h5555);
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_valid", 160'(triangle_valid_out), 160'(0));
      check("rst_mid_ready", 160'(tri_ready_out), 160'(1));
      check("rst_mid_out", triangle_out, 160'(0));
      expq.delete();
      @(negedge clk);
      rst = 1'b0;
      send(v_simple, scr, 16'hBEEF);
      drain();

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
